// File: rtl/msj_pwm_driver_if.sv
`timescale 1ns/1ps
// Signal bundle between the PD controller side (master) and the PWM driver (slave).
interface msj_pwm_driver_if;
  logic               enable;
  logic signed [31:0] duty;
  logic               pwm_hi;
  logic               pwm_lo;
  logic               update_controller;
  logic [31:0]        duty_applied;
  logic               saturated;

  modport master (
    output enable,
    output duty,
    input  pwm_hi,
    input  pwm_lo,
    input  update_controller,
    input  duty_applied,
    input  saturated
  );

  modport slave (
    input  enable,
    input  duty,
    output pwm_hi,
    output pwm_lo,
    output update_controller,
    output duty_applied,
    output saturated
  );
endinterface

// File: rtl/msj_pwm_driver.sv
`timescale 1ns/1ps
// Complementary dead-time PWM stage for one H-bridge half; also emits the
// 2-clock update strobe that paces the PD controller once per UPDATE_DIV periods.
module msj_pwm_driver #(
  parameter int CLK_DIV     = 50,
  parameter int PERIOD      = 100,
  parameter int DEAD_CYCLES = 10,
  parameter int UPDATE_DIV  = 1
) (
  input logic              clk,
  input logic              rst_n,
  msj_pwm_driver_if.slave  bus
);

  localparam int PSW = (CLK_DIV > 1)     ? $clog2(CLK_DIV)         : 1;
  localparam int CW  = (PERIOD > 1)      ? $clog2(PERIOD)          : 1;
  localparam int PCW = (UPDATE_DIV > 1)  ? $clog2(UPDATE_DIV)      : 1;
  localparam int RW  = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

  localparam logic [PSW-1:0]     PRESC_LAST = PSW'(CLK_DIV - 1);
  localparam logic [CW-1:0]      CNT_LAST   = CW'(PERIOD - 1);
  localparam logic [PCW-1:0]     PC_LAST    = PCW'(UPDATE_DIV - 1);
  localparam logic [RW-1:0]      RL_SAT     = RW'(DEAD_CYCLES);
  localparam logic signed [31:0] PERIOD_S   = 32'(PERIOD);
  localparam logic [31:0]        PERIOD_U   = 32'(PERIOD);

  logic           en_q,      en_d;
  logic [PSW-1:0] presc_q,   presc_d;
  logic [CW-1:0]  cnt_q,     cnt_d;
  logic [PCW-1:0] pc_q,      pc_d;
  logic [RW-1:0]  rl_q,      rl_d;
  logic           raw_q,     raw_d;
  logic           hi_q,      hi_d;
  logic           lo_q,      lo_d;
  logic           stb1_q,    stb1_d;
  logic           upd_q,     upd_d;
  logic [31:0]    duty_app_q, duty_app_d;
  logic           sat_q,     sat_d;

  logic start_s;
  logic tick_s;
  logic period_end_s;
  logic boundary_s;

  function automatic logic [31:0] clamp_duty(input logic signed [31:0] d);
    logic [31:0] r;
    if (d < 32'sd0) begin
      r = 32'd0;
    end else if (d > PERIOD_S) begin
      r = PERIOD_U;
    end else begin
      r = d;
    end
    return r;
  endfunction

  function automatic logic duty_out_of_range(input logic signed [31:0] d);
    return (d < 32'sd0) || (d > PERIOD_S);
  endfunction

  // Next-state logic: prescaler, period counter, duty sampling, dead time and strobe.
  always_comb begin
    en_d       = bus.enable;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    rl_d       = rl_q;
    raw_d      = raw_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    stb1_d     = stb1_q;
    upd_d      = upd_q;
    duty_app_d = duty_app_q;
    sat_d      = sat_q;

    start_s      = bus.enable && !en_q;
    tick_s       = (presc_q == PRESC_LAST);
    period_end_s = bus.enable && !start_s && tick_s && (cnt_q == CNT_LAST);
    boundary_s   = start_s || period_end_s;

    if (!bus.enable) begin
      presc_d = '0;
      cnt_d   = '0;
      pc_d    = '0;
      rl_d    = '0;
      raw_d   = 1'b0;
      hi_d    = 1'b0;
      lo_d    = 1'b0;
      stb1_d  = 1'b0;
      upd_d   = 1'b0;
    end else begin
      presc_d = tick_s ? '0 : presc_q + PSW'(1);

      if (start_s) begin
        cnt_d = '0;
      end else if (tick_s) begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end

      if (boundary_s) begin
        duty_app_d = clamp_duty(bus.duty);
        sat_d      = duty_out_of_range(bus.duty);
      end else begin
        duty_app_d = duty_app_q;
        sat_d      = sat_q;
      end

      if (period_end_s) begin
        pc_d = (pc_q == PC_LAST) ? '0 : pc_q + PCW'(1);
      end else begin
        pc_d = pc_q;
      end

      // Two flops in series give the 2-clock strobe; a new one can only start a full period later.
      stb1_d = period_end_s && (pc_q == PC_LAST);
      upd_d  = stb1_d || stb1_q;

      // raw is computed from next-state values so raw_q always matches cnt_q/duty_app_q.
      raw_d = (32'(cnt_d) < duty_app_d);

      if (raw_d != raw_q) begin
        rl_d = '0;
      end else if (rl_q >= RL_SAT) begin
        rl_d = rl_q;
      end else begin
        rl_d = rl_q + RW'(1);
      end

      hi_d = raw_q && (rl_q >= RL_SAT);
      lo_d = !raw_q && (rl_q >= RL_SAT);
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      presc_q    <= '0;
      cnt_q      <= '0;
      pc_q       <= '0;
      rl_q       <= '0;
      raw_q      <= 1'b0;
      hi_q       <= 1'b0;
      lo_q       <= 1'b0;
      stb1_q     <= 1'b0;
      upd_q      <= 1'b0;
      duty_app_q <= 32'd0;
      sat_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      rl_q       <= rl_d;
      raw_q      <= raw_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      stb1_q     <= stb1_d;
      upd_q      <= upd_d;
      duty_app_q <= duty_app_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.pwm_hi            = hi_q;
  assign bus.pwm_lo            = lo_q;
  assign bus.update_controller = upd_q;
  assign bus.duty_applied      = duty_app_q;
  assign bus.saturated         = sat_q;

endmodule

// File: tb/tb_msj_pwm_driver.sv
`timescale 1ns/1ps
// Scoreboard bench for msj_pwm_driver: stimulus queues per-window expectations,
// a monitor measures each strobe-to-strobe window of the outputs and compares.
module tb_msj_pwm_driver;

  typedef struct {
    string name;
    int    hi;
    int    lo;
    int    fall;
    int    da;
    int    sat;
  } win_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n_b;
  always #5 clk = ~clk;

  msj_pwm_driver_if bus_a();
  msj_pwm_driver_if bus_b();

  msj_pwm_driver #(.CLK_DIV(2), .PERIOD(10), .DEAD_CYCLES(1), .UPDATE_DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  msj_pwm_driver #(.CLK_DIV(2), .PERIOD(10), .DEAD_CYCLES(0), .UPDATE_DIV(3)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(bus_b)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  win_t sb_q[$];
  bit   arm_a    = 1'b0;
  int   overlap_a = 0;
  int   overlap_b = 0;
  int   b_checked = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push(input string name, input int hi, input int lo, input int fall,
                      input int da, input int sat);
    win_t w;
    w.name = name; w.hi = hi; w.lo = lo; w.fall = fall; w.da = da; w.sat = sat;
    sb_q.push_back(w);
  endtask

  // Returns #1 after the negedge of the strobe-rise cycle that empties the queue.
  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL %s_timeout: %0d windows still pending, expected 0", name, sb_q.size());
    end
  endtask

  // Monitor for dut_a: windows run from one strobe rise to the next.
  initial begin
    bit   have_prev, prev_hi, prev_upd, rise;
    int   c_hi, c_lo, c_upd, len, fall, win_da, win_sat;
    win_t e;
    have_prev = 0; prev_hi = 0; prev_upd = 0;
    c_hi = 0; c_lo = 0; c_upd = 0; len = 0; fall = -1; win_da = 0; win_sat = 0;
    forever begin
      @(negedge clk);
      if (bus_a.pwm_hi && bus_a.pwm_lo) overlap_a++;
      rise = bus_a.update_controller && !prev_upd;
      if (!arm_a) begin
        have_prev = 0;
      end else if (rise) begin
        if (have_prev) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_underflow: window with no expectation, got 0 entries, need 1");
          end else begin
            e = sb_q.pop_front();
            check({e.name, "_hi"},   c_hi,    e.hi);
            check({e.name, "_lo"},   c_lo,    e.lo);
            check({e.name, "_fall"}, fall,    e.fall);
            check({e.name, "_da"},   win_da,  e.da);
            check({e.name, "_sat"},  win_sat, e.sat);
            check({e.name, "_len"},  len,     20);
            check({e.name, "_stb"},  c_upd,   2);
          end
        end
        have_prev = 1;
        c_hi = 0; c_lo = 0; c_upd = 0; len = 0; fall = -1;
        win_da  = int'(bus_a.duty_applied);
        win_sat = int'(bus_a.saturated);
      end
      if (len >= 1 && prev_hi && !bus_a.pwm_hi && fall < 0) fall = len;
      c_hi  += int'(bus_a.pwm_hi);
      c_lo  += int'(bus_a.pwm_lo);
      c_upd += int'(bus_a.update_controller);
      len++;
      prev_hi  = bus_a.pwm_hi;
      prev_upd = bus_a.update_controller;
    end
  end

  // Monitor for dut_b (UPDATE_DIV=3, no dead time): 60-clock windows, strict complement.
  initial begin
    bit have_prev, prev_upd, rise;
    int c_hi, c_lo, c_upd, len, mis;
    have_prev = 0; prev_upd = 0;
    c_hi = 0; c_lo = 0; c_upd = 0; len = 0; mis = 0;
    forever begin
      @(negedge clk);
      if (bus_b.pwm_hi && bus_b.pwm_lo) overlap_b++;
      rise = bus_b.update_controller && !prev_upd;
      if (rise) begin
        if (have_prev && b_checked < 4) begin
          check("b_len",   len,   60);
          check("b_hi",    c_hi,  18);
          check("b_lo",    c_lo,  42);
          check("b_stb",   c_upd, 2);
          check("b_compl", mis,   0);
          b_checked++;
        end
        have_prev = 1;
        c_hi = 0; c_lo = 0; c_upd = 0; len = 0; mis = 0;
      end
      if (bus_b.pwm_lo == bus_b.pwm_hi) mis++;
      c_hi  += int'(bus_b.pwm_hi);
      c_lo  += int'(bus_b.pwm_lo);
      c_upd += int'(bus_b.update_controller);
      len++;
      prev_upd = bus_b.update_controller;
    end
  end

  initial begin
    int first_stb;
    int toggles;
    rst_n = 1'b0; rst_n_b = 1'b0;
    bus_a.enable = 1'b0; bus_a.duty = 32'sd0;
    bus_b.enable = 1'b0; bus_b.duty = 32'sd0;
    #12;
    check("rst_hi",  bus_a.pwm_hi, 0);
    check("rst_lo",  bus_a.pwm_lo, 0);
    check("rst_stb", bus_a.update_controller, 0);
    check("rst_da",  bus_a.duty_applied, 0);
    check("rst_sat", bus_a.saturated, 0);
    @(negedge clk);
    rst_n = 1'b1; rst_n_b = 1'b1;

    // Basic 4-tick duty on A; B runs duty 3 for the whole test.
    bus_b.duty = 32'sd3; bus_b.enable = 1'b1;
    bus_a.duty = 32'sd4; bus_a.enable = 1'b1; arm_a = 1'b1;
    push("d4_a", 7, 11, 9, 4, 0);
    push("d4_b", 7, 11, 9, 4, 0);
    push("d4_c", 7, 11, 9, 4, 0);
    drain("t1");

    // Saturation low, then high, then exactly PERIOD.
    bus_a.duty = -32'sd7;
    push("d4_d",      7, 11,  9, 4, 0);
    push("neg_first", 0, 20, -1, 0, 1);
    push("neg_hold",  0, 20, -1, 0, 1);
    drain("t2a");
    bus_a.duty = 32'sd25;
    push("neg_last",   0, 20, -1,  0, 1);
    push("big_first", 18,  1, -1, 10, 1);
    push("big_hold",  20,  0, -1, 10, 1);
    drain("t2b");
    bus_a.duty = 32'sd10;
    push("big_last", 20, 0, -1, 10, 1);
    push("full",     20, 0, -1, 10, 0);
    drain("t2c");
    bus_a.duty = 32'sd4;
    push("full_last", 20,  0, -1, 10, 0);
    push("back4",      9, 10,  9,  4, 0);
    push("d4_e",       7, 11,  9,  4, 0);
    drain("t2d");

    // Duty change at cnt=2 must wait for the next period.
    push("keep4", 7, 11, 9, 4, 0);
    push("to7",  13,  5, 15, 7, 0);
    push("d7",   13,  5, 15, 7, 0);
    repeat (4) @(negedge clk);
    check("t3_cnt_at_change", dut_a.cnt_q, 2);
    bus_a.duty = 32'sd7;
    drain("t3");

    // Enable drop during the high phase.
    arm_a = 1'b0;
    repeat (6) @(negedge clk);
    check("t4_hi_before_drop", bus_a.pwm_hi, 1);
    bus_a.enable = 1'b0;
    @(negedge clk); #1;
    check("t4_hi_off",  bus_a.pwm_hi, 0);
    check("t4_lo_off",  bus_a.pwm_lo, 0);
    check("t4_stb_off", bus_a.update_controller, 0);
    check("t4_cnt",     dut_a.cnt_q, 0);
    check("t4_presc",   dut_a.presc_q, 0);
    check("t4_rl",      dut_a.rl_q, 0);
    check("t4_da_hold", bus_a.duty_applied, 7);
    repeat (3) @(negedge clk);
    bus_a.enable = 1'b1; arm_a = 1'b1;
    push("reen", 13, 5, 15, 7, 0);
    first_stb = -1;
    for (int n = 1; n <= 100 && first_stb < 0; n++) begin
      @(negedge clk);
      if (n == 1) check("t4_start_cnt", dut_a.cnt_q, 0);
      if (bus_a.update_controller) first_stb = n;
    end
    check("t4_first_strobe_clk", first_stb, 20);
    drain("t4");

    // Reset asserted while the strobe is high.
    arm_a = 1'b0;
    check("t5_stb_before", bus_a.update_controller, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_stb_async", bus_a.update_controller, 0);
    check("t5_hi", bus_a.pwm_hi, 0);
    check("t5_lo", bus_a.pwm_lo, 0);
    check("t5_da", bus_a.duty_applied, 0);
    bus_a.enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    toggles = 0;
    repeat (5) begin
      @(negedge clk);
      toggles += int'(bus_a.pwm_hi) + int'(bus_a.pwm_lo) + int'(bus_a.update_controller);
    end
    check("t5_quiet_after_release", toggles, 0);
    bus_a.enable = 1'b1; arm_a = 1'b1;
    push("post_rst", 13, 5, 15, 7, 0);
    drain("t5");

    check("a_never_both_high", overlap_a, 0);
    check("b_never_both_high", overlap_b, 0);
    check("b_windows_seen",    b_checked, 4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
